usb_stat_matcher: RTL and testbench

Multi-channel USB line-state (STAT) match monitor with its own register window. It is the parametrised successor to the single pattern/mask STAT capture in the USB register block. It provides N independent pattern/mask channels, per-channel saturating event counters, first-match capture, and an ordered-sequence trigger mode. It sits on the cwusb_clk register bus beside the USB register block and is fed with STAT already synchronised to cwusb_clk.

---
 rtl/usb_stat_matcher.sv | 225 ++++++++++++++++++++++
 tb/tb_usb_stat_matcher.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_stat_matcher.sv
// Multi-channel USB STAT pattern/mask match monitor with saturating counters, first-match
// capture and ordered-sequence trigger. Define USB_STAT_MATCH_TIMESTAMP_EN for timestamps.
module usb_stat_matcher #(
    parameter int         pNUM_CHANNELS    = 4,
    parameter int         pSTAT_WIDTH      = 5,
    parameter int         pCOUNT_WIDTH     = 16,
    parameter int         pTIMESTAMP_WIDTH = 24,
    parameter int         pBYTECNT_SIZE    = 7,
    parameter logic [1:0] pREG_SELECT      = 2'b11
) (
    input  logic                     cwusb_clk,
    input  logic                     reset_n,
    input  logic [7:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic                     reg_addrvalid,
    input  logic                     reg_read,
    input  logic                     reg_write,
    input  logic [7:0]               write_data,
    output logic [7:0]               read_data,
    output logic                     selected,
    input  logic [pSTAT_WIDTH-1:0]   I_stat,
    input  logic                     I_arm,
    output logic [pNUM_CHANNELS-1:0] O_channel_matched,
    output logic                     O_match_any,
    output logic                     O_seq_done
);
    localparam int NC = pNUM_CHANNELS;
    localparam int SW = pSTAT_WIDTH;
    localparam int CW = pCOUNT_WIDTH;
    localparam int BW = pBYTECNT_SIZE;
    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [5:0]            laddr;
    logic                  wr_en, restart;
    logic [7:0]            read_data_q, read_data_d;
    logic                  enable_q, enable_d, seq_mode_q, seq_mode_d;
    logic [NC-1:0][SW-1:0] pattern_q, pattern_d, mask_q, mask_d;
    logic [7:0]            chan_sel_q, chan_sel_d;
    logic [SW-1:0]         stat_q;
    logic                  arm_q, arm_r_q;
    logic [NC-1:0]         match, evt, match_r_q;
    logic [NC-1:0]         flags_q, flags_d;
    logic [NC-1:0][CW-1:0] count_q, count_d;
    logic [NC-1:0][SW-1:0] captured_q, captured_d;
    logic [0:0]            state_q, state_d;
    logic [2:0]            seq_index_q, seq_index_d;
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
    localparam int TW = pTIMESTAMP_WIDTH;
    logic [TW-1:0]         ts_q, ts_d;
    logic [NC-1:0][TW-1:0] ts_cap_q, ts_cap_d;
`endif

    assign laddr             = reg_address[5:0];
    assign selected          = reg_addrvalid & (reg_address[7:6] == pREG_SELECT);
    assign wr_en             = selected & reg_write;
    assign restart           = (wr_en && laddr == 6'h00 && reg_bytecnt == '0 && write_data[2])
                             | (arm_q & ~arm_r_q);
    assign read_data         = read_data_q;
    assign O_channel_matched = flags_q;
    assign O_match_any       = |flags_q;
    assign O_seq_done        = (state_q == ST_DONE);

    always_comb begin
        for (int i = 0; i < NC; i++)
            match[i] = ((stat_q ^ pattern_q[i]) & mask_q[i]) == '0;
        evt = match & ~match_r_q;
    end

    // Register-window writes
    always_comb begin
        enable_d   = enable_q;
        seq_mode_d = seq_mode_q;
        pattern_d  = pattern_q;
        mask_d     = mask_q;
        chan_sel_d = chan_sel_q;
        if (wr_en) begin
            case (laddr)
                6'h00: if (reg_bytecnt == '0) begin
                    enable_d   = write_data[0];
                    seq_mode_d = write_data[1];
                end
                6'h02: for (int i = 0; i < NC; i++)
                    if (reg_bytecnt == BW'(i)) pattern_d[i] = write_data[SW-1:0];
                6'h03: for (int i = 0; i < NC; i++)
                    if (reg_bytecnt == BW'(i)) mask_d[i] = write_data[SW-1:0];
                6'h05: if (reg_bytecnt == '0) chan_sel_d = write_data;
                default: ;
            endcase
        end
    end

    // Match engine: counters, first-match capture, sequence FSM
    always_comb begin
        flags_d     = flags_q;
        count_d     = count_q;
        captured_d  = captured_q;
        state_d     = state_q;
        seq_index_d = seq_index_q;
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
        ts_d        = ts_q;
        ts_cap_d    = ts_cap_q;
`endif
        if (restart) begin
            flags_d     = '0;
            count_d     = '0;
            captured_d  = '0;
            state_d     = ST_WAIT;
            seq_index_d = '0;
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
            ts_d        = '0;
            ts_cap_d    = '0;
`endif
        end else if (enable_q) begin
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
            if (ts_q != '1) ts_d = ts_q + TW'(1);
`endif
            for (int i = 0; i < NC; i++)
                if (evt[i] && count_q[i] != '1) count_d[i] = count_q[i] + CW'(1);
            if (!seq_mode_q) begin
                for (int i = 0; i < NC; i++) begin
                    if (evt[i] && !flags_q[i]) begin
                        flags_d[i]    = 1'b1;
                        captured_d[i] = stat_q;
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
                        ts_cap_d[i]   = ts_q;
`endif
                    end
                end
            end else if (state_q == ST_WAIT) begin
                // Only the channel the sequence is waiting on may advance it
                for (int k = 0; k < NC; k++) begin
                    if (seq_index_q == 3'(k) && evt[k]) begin
                        flags_d[k]    = 1'b1;
                        captured_d[k] = stat_q;
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
                        ts_cap_d[k]   = ts_q;
`endif
                        if (k == NC - 1) begin
                            state_d     = ST_DONE;
                            seq_index_d = '0;
                        end else begin
                            seq_index_d = 3'(k + 1);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        read_data_d = '0;
        if (selected && reg_read) begin
            case (laddr)
                6'h00: if (reg_bytecnt == '0) read_data_d = {6'b0, seq_mode_q, enable_q};
                6'h01: begin
                    if (reg_bytecnt == BW'(0)) read_data_d = 8'(flags_q);
                    if (reg_bytecnt == BW'(1)) read_data_d = {state_q == ST_DONE, 4'b0, seq_index_q};
                end
                6'h02: for (int i = 0; i < NC; i++)
                    if (reg_bytecnt == BW'(i)) read_data_d = 8'(pattern_q[i]);
                6'h03: for (int i = 0; i < NC; i++)
                    if (reg_bytecnt == BW'(i)) read_data_d = 8'(mask_q[i]);
                6'h04: for (int i = 0; i < NC; i++)
                    if (reg_bytecnt == BW'(i)) read_data_d = 8'(captured_q[i]);
                6'h05: if (reg_bytecnt == '0) read_data_d = chan_sel_q;
                6'h06: for (int i = 0; i < NC; i++)
                    for (int b = 0; b < CW / 8; b++)
                        if (chan_sel_q == 8'(i) && reg_bytecnt == BW'(b))
                            read_data_d = count_q[i][b*8 +: 8];
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
                6'h07: for (int i = 0; i < NC; i++)
                    for (int b = 0; b < TW / 8; b++)
                        if (chan_sel_q == 8'(i) && reg_bytecnt == BW'(b))
                            read_data_d = ts_cap_q[i][b*8 +: 8];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_q <= '0;
            enable_q    <= 1'b0;
            seq_mode_q  <= 1'b0;
            pattern_q   <= '0;
            mask_q      <= '0;
            chan_sel_q  <= '0;
            stat_q      <= '0;
            arm_q       <= 1'b0;
            arm_r_q     <= 1'b0;
            match_r_q   <= '0;
            flags_q     <= '0;
            count_q     <= '0;
            captured_q  <= '0;
            state_q     <= ST_WAIT;
            seq_index_q <= '0;
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
            ts_q        <= '0;
            ts_cap_q    <= '0;
`endif
        end else begin
            read_data_q <= read_data_d;
            enable_q    <= enable_d;
            seq_mode_q  <= seq_mode_d;
            pattern_q   <= pattern_d;
            mask_q      <= mask_d;
            chan_sel_q  <= chan_sel_d;
            stat_q      <= I_stat;
            arm_q       <= I_arm;
            arm_r_q     <= arm_q;
            match_r_q   <= match;
            flags_q     <= flags_d;
            count_q     <= count_d;
            captured_q  <= captured_d;
            state_q     <= state_d;
            seq_index_q <= seq_index_d;
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
            ts_q        <= ts_d;
            ts_cap_q    <= ts_cap_d;
`endif
        end
    end
endmodule

// File: tb/tb_usb_stat_matcher.sv
// Scoreboard bench for usb_stat_matcher: expectations are queued when stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_usb_stat_matcher;
    localparam int NC = 4, SW = 5, CW = 8, TW = 24;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [7:0]    reg_address = '0;
    logic [6:0]    reg_bytecnt = '0;
    logic          reg_addrvalid = 1'b0, reg_read = 1'b0, reg_write = 1'b0;
    logic [7:0]    write_data = '0;
    logic [7:0]    read_data;
    logic          selected;
    logic [SW-1:0] I_stat = '0;
    logic          I_arm = 1'b0;
    logic [NC-1:0] O_channel_matched;
    logic          O_match_any, O_seq_done;

    int         total = 0, bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e, d;

    usb_stat_matcher #(.pNUM_CHANNELS(NC), .pSTAT_WIDTH(SW), .pCOUNT_WIDTH(CW),
                       .pTIMESTAMP_WIDTH(TW), .pBYTECNT_SIZE(7), .pREG_SELECT(2'b11)) dut (
        .cwusb_clk(clk), .reset_n(rst_n), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .reg_addrvalid(reg_addrvalid), .reg_read(reg_read), .reg_write(reg_write),
        .write_data(write_data), .read_data(read_data), .selected(selected), .I_stat(I_stat),
        .I_arm(I_arm), .O_channel_matched(O_channel_matched), .O_match_any(O_match_any),
        .O_seq_done(O_seq_done));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [5:0] a, input int bc, input logic [7:0] v);
        reg_address = {2'b11, a}; reg_bytecnt = 7'(bc); write_data = v;
        reg_addrvalid = 1'b1; reg_write = 1'b1;
        tick;
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input int bc, output logic [7:0] v);
        reg_address = {2'b11, a}; reg_bytecnt = 7'(bc);
        reg_addrvalid = 1'b1; reg_read = 1'b1;
        tick;
        v = read_data;
        reg_read = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic test_reset;
        exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
        if ({O_channel_matched, O_match_any, O_seq_done} !== e[5:0]) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", {O_channel_matched, O_match_any, O_seq_done}, e);
        end
        tick; tick; rst_n = 1'b1; tick;
        exp_q.push_back(8'h00); rd(6'h00, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", d, e); end
        exp_q.push_back(8'h00); rd(6'h01, 1, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL reset_status1 got=%h exp=%h", d, e); end
    endtask

    task automatic test_any_mode;
        wr(6'h02, 0, 8'h03); wr(6'h03, 0, 8'h1F); wr(6'h00, 0, 8'h01);
        I_stat = 5'h03;
        exp_q.push_back(8'h00); tick; e = exp_q.pop_front(); total++;
        if (8'(O_channel_matched) !== e) begin bad++; $display("FAIL any_latency1 got=%h exp=%h", O_channel_matched, e); end
        exp_q.push_back(8'h01); tick; e = exp_q.pop_front(); total++;
        if (8'(O_channel_matched) !== e || !O_match_any) begin
            bad++; $display("FAIL any_flag got=%h any=%b exp=%h", O_channel_matched, O_match_any, e);
        end
        tick;
        exp_q.push_back(8'h03); rd(6'h04, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL any_captured got=%h exp=%h", d, e); end
        wr(6'h05, 0, 8'h00);
        exp_q.push_back(8'h01); rd(6'h06, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL any_count got=%h exp=%h", d, e); end
        exp_q.push_back(8'h00); rd(6'h06, 1, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL count_beyond_width got=%h exp=%h", d, e); end
        exp_q.push_back(8'h01); rd(6'h00, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL ctrl_readback got=%h exp=%h", d, e); end
    endtask

    task automatic test_saturate;
        logic [CW-1:0] m;
        m = '0;
        wr(6'h00, 0, 8'h05); wr(6'h02, 1, 8'h05); wr(6'h03, 1, 8'h1F);
        for (int n = 0; n < 300; n++) begin
            I_stat = 5'h05; tick; I_stat = 5'h00; tick;
            if (m != '1) m = m + 1'b1;
        end
        exp_q.push_back(8'(m)); tick; tick;
        wr(6'h05, 0, 8'h01); rd(6'h06, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL sat_count got=%h exp=%h", d, e); end
        exp_q.push_back(8'h02); e = exp_q.pop_front(); total++;
        if (8'(O_channel_matched) !== e) begin bad++; $display("FAIL sat_flags got=%h exp=%h", O_channel_matched, e); end
        exp_q.push_back(8'h00); wr(6'h05, 0, 8'h04); rd(6'h06, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL chansel_oob got=%h exp=%h", d, e); end
    endtask

    task automatic test_arm_restart;
        I_arm = 1'b1;
        exp_q.push_back(8'h02); tick; e = exp_q.pop_front(); total++;
        if (8'(O_channel_matched) !== e) begin bad++; $display("FAIL arm_before got=%h exp=%h", O_channel_matched, e); end
        exp_q.push_back(8'h00); tick; e = exp_q.pop_front(); total++;
        if (8'(O_channel_matched) !== e) begin bad++; $display("FAIL arm_restart got=%h exp=%h", O_channel_matched, e); end
        I_arm = 1'b0;
        exp_q.push_back(8'h00); wr(6'h05, 0, 8'h01); rd(6'h06, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL arm_count got=%h exp=%h", d, e); end
    endtask

    task automatic test_seq;
        logic [SW-1:0] seq[7] = '{5'd2, 5'd1, 5'd3, 5'd2, 5'd4, 5'd3, 5'd4};
        int k, prev, cnt[NC];
        logic done;
        wr(6'h00, 0, 8'h00);
        for (int c = 0; c < NC; c++) begin wr(6'h02, c, 8'(c + 1)); wr(6'h03, c, 8'h1F); cnt[c] = 0; end
        I_stat = '0; tick; wr(6'h00, 0, 8'h07);
        k = 0; prev = 0; done = 1'b0;
        for (int j = 0; j < 7; j++) begin
            I_stat = seq[j];
            if (int'(seq[j]) != prev) begin
                cnt[seq[j] - 1]++;
                if (!done && int'(seq[j]) == k + 1) begin k++; if (k == NC) begin done = 1'b1; k = 0; end end
            end
            prev = int'(seq[j]);
            exp_q.push_back(8'(done));
            tick;
            if (j > 0) begin
                e = exp_q.pop_front(); total++;
                if (8'(O_seq_done) !== e) begin bad++; $display("FAIL seq_done_step%0d got=%b exp=%h", j - 1, O_seq_done, e); end
            end
        end
        tick; e = exp_q.pop_front(); total++;
        if (8'(O_seq_done) !== e) begin bad++; $display("FAIL seq_done_final got=%b exp=%h", O_seq_done, e); end
        exp_q.push_back({done, 4'b0, 3'(k)}); rd(6'h01, 1, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL seq_status1 got=%h exp=%h", d, e); end
        exp_q.push_back(8'h0F); rd(6'h01, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL seq_flags got=%h exp=%h", d, e); end
        exp_q.push_back(8'(cnt[1])); wr(6'h05, 0, 8'h01); rd(6'h06, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL seq_count1 got=%h exp=%h", d, e); end
    endtask

    task automatic test_clear_collision;
        wr(6'h00, 0, 8'h05); I_stat = '0; tick; tick;
        I_stat = 5'h01; tick;
        wr(6'h00, 0, 8'h05);
        exp_q.push_back(8'h00); tick; e = exp_q.pop_front(); total++;
        if (8'(O_channel_matched) !== e) begin bad++; $display("FAIL collide_flag got=%h exp=%h", O_channel_matched, e); end
        exp_q.push_back(8'h00); wr(6'h05, 0, 8'h00); rd(6'h06, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL collide_count got=%h exp=%h", d, e); end
        exp_q.push_back(8'h01); rd(6'h00, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL clear_reads_zero got=%h exp=%h", d, e); end
    endtask

    task automatic test_timestamp;
        int cyc;
        I_stat = '0; tick; tick;
        wr(6'h00, 0, 8'h05); cyc = 0;
        for (int n = 0; n < 9; n++) begin tick; cyc++; end
        I_stat = 5'h03; tick; cyc++;
`ifdef USB_STAT_MATCH_TIMESTAMP_EN
        exp_q.push_back(8'(cyc));
`else
        exp_q.push_back(8'h00);
`endif
        tick;
        exp_q.push_back(8'h04); e = exp_q.pop_back(); total++;
        if (8'(O_channel_matched) !== e) begin bad++; $display("FAIL ts_flag got=%h exp=%h", O_channel_matched, e); end
        wr(6'h05, 0, 8'h02); rd(6'h07, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL ts_byte0 got=%h exp=%h", d, e); end
        for (int b = 1; b < 4; b++) begin
            exp_q.push_back(8'h00); rd(6'h07, b, d); e = exp_q.pop_front(); total++;
            if (d !== e) begin bad++; $display("FAIL ts_byte%0d got=%h exp=%h", b, d, e); end
        end
    endtask

    task automatic test_decode;
        reg_address = 8'h06; reg_bytecnt = '0; reg_addrvalid = 1'b1; reg_read = 1'b1; #1;
        exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
        if (8'(selected) !== e) begin bad++; $display("FAIL unselected_sel got=%b exp=%h", selected, e); end
        exp_q.push_back(8'h00); tick; e = exp_q.pop_front(); total++;
        if (read_data !== e) begin bad++; $display("FAIL unselected_read got=%h exp=%h", read_data, e); end
        reg_read = 1'b0; reg_addrvalid = 1'b0;
        exp_q.push_back(8'h00); rd(6'h08, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL bad_addr got=%h exp=%h", d, e); end
        exp_q.push_back(8'h00); tick; e = exp_q.pop_front(); total++;
        if (read_data !== e) begin bad++; $display("FAIL idle_read got=%h exp=%h", read_data, e); end
    endtask

    task automatic test_reset_mid;
        wr(6'h00, 0, 8'h00); I_stat = '0; tick; wr(6'h00, 0, 8'h07);
        I_stat = 5'h01; tick; I_stat = 5'h02; tick; tick;
        exp_q.push_back(8'h02); rd(6'h01, 1, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL mid_wait2 got=%h exp=%h", d, e); end
        #2 rst_n = 1'b0; #1;
        exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
        if ({read_data, O_channel_matched, O_match_any, O_seq_done} !== {e, 6'h00}) begin
            bad++; $display("FAIL mid_async got rd=%h m=%h any=%b done=%b exp=0", read_data, O_channel_matched, O_match_any, O_seq_done);
        end
        tick; rst_n = 1'b1; tick;
        exp_q.push_back(8'h00); rd(6'h01, 1, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL mid_wait0 got=%h exp=%h", d, e); end
        exp_q.push_back(8'h00); rd(6'h00, 0, d); e = exp_q.pop_front(); total++;
        if (d !== e) begin bad++; $display("FAIL mid_ctrl got=%h exp=%h", d, e); end
    endtask

    initial begin
        #3;
        test_reset;
        test_any_mode;
        test_saturate;
        test_arm_restart;
        test_seq;
        test_clear_collision;
        test_timestamp;
        test_decode;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
